alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised integer execute stage for the RV32I core: all R/I-type ALU ops with valid/ready handshakes.
//  Single-cycle for logic/arith ops; shifts run on a serial shifter (SHIFT_STEP bits/cycle) to save LEs on DE10-Nano.
//  Sits between decode/regfile read and writeback; the write_addr/result pair feeds the regfile write port.
//  Flushed by the jump/branch unit.
// PARAMETERS
//  XLEN        32  datapath width (power of two, >=8)
//  AW          5   register address width
//  SHIFT_STEP  1   shift bits per cycle, power of two, 1..XLEN
// PORTS
//  clk           in   1     clock; all state changes on posedge
//  reset_n       in   1     reset, synchronous, active-low
//  flush         in   1     jump/branch taken: kill in-flight and pending op
//  in_valid      in   1     operation presented
//  in_ready      out  1     stage can accept operation
//  op            in   4     {funct7[5],funct3} encoding, see alu_pkg
//  use_imm       in   1     1: operand B = imm (I-type); 0: src2_value
//  src1_addr     in   AW    rs1 index (forwarding compare)
//  src2_addr     in   AW    rs2 index (forwarding compare)
//  src1_value    in   XLEN  rs1 value from regfile
//  src2_value    in   XLEN  rs2 value from regfile
//  imm           in   XLEN  sign-extended immediate
//  rd            in   AW    destination index
//  out_valid     out  1     result/write_addr valid
//  out_ready     in   1     writeback accepts result
//  write_addr    out  AW    destination of current result
//  result        out  XLEN  operation result
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): FSM=IDLE, out_valid=0, result=0, write_addr=0, in_ready=0 that cycle, bypass invalid.
//  - Accept when in_valid & in_ready. in_ready=1 in IDLE when !out_valid or out_ready (output slot frees same cycle).
//  - FSM IDLE->IDLE: non-shift op; result registered next cycle (latency 1), out_valid=1.
//  - IDLE->SHIFT: SLL/SRL/SRA; shamt=B[log2(XLEN)-1:0]; each cycle shifts min(SHIFT_STEP,remaining).
//    SHIFT->DONE when remaining=0; DONE loads output reg -> IDLE. Latency = ceil(shamt/SHIFT_STEP)+1; shamt=0 -> 1 (SHIFT skipped, A passed through).
//  - in_ready=0 in SHIFT/DONE. Output held stable while out_valid & !out_ready.
//  - Arithmetic: ADD/SUB modulo 2^XLEN, no flags; SLT signed, SLTU unsigned, result zero-extended 0/1.
//    SRA replicates A[XLEN-1]; SUB only with use_imm=0 (op 4'b1000 with use_imm=1 decodes as ADD).
//  - Undefined op codes: result=0, write_addr=rd, out_valid asserted normally.
//  - flush=1 at posedge: out_valid->0, FSM->IDLE, shifter cleared, input that cycle dropped even if in_valid; in_ready=0.
//    Priority: reset > flush > accept. Bypass register unaffected by flush (its value is architecturally committed).
//  - rd=0: op executes, write_addr=0 output; never becomes bypass source.
// CONFIGURATION
//  ALU_BYPASS_EN defined: bypass reg {byp_valid,byp_addr,byp_data} loads on each out_valid&out_ready with write_addr!=0.
//    Operand A/B replaced by byp_data when byp_valid and srcN_addr==byp_addr (B only when use_imm=0); also
//    forwards the current output reg when out_valid & write_addr==srcN_addr !=0 (output reg has priority).
//  ALU_BYPASS_EN undefined: operands taken from src1_value/src2_value only; src*_addr unused; no bypass regs.
// STRUCTURE
//  alu_pkg: op localparams OP_ADD=0000, OP_SLL=0001, OP_SLT=0010, OP_SLTU=0011, OP_XOR=0100, OP_SRL=0101,
//    OP_OR=0110, OP_AND=0111, OP_SUB=1000, OP_SRA=1101; FSM state encodings S_IDLE/S_SHIFT/S_DONE.
//  Sub-module alu_shifter: serial shifter (load, dir, arith, shamt) -> busy/done/data, parametrised by XLEN, SHIFT_STEP.
//  Top: handshake, operand mux/bypass, single-cycle op logic, output register.
// TESTING
//  ADD A=0x7FFFFFFF,B=1 -> result 0x80000000, out_valid one cycle after accept; SUB 0,1 -> 0xFFFFFFFF.
//  SLT A=0xFFFFFFFF,B=1 -> 1; SLTU same -> 0; SRA 0x80000000 by 31 (STEP=1) -> 0xFFFFFFFF after 32 cycles.
//  Back-to-back ADD x1=5+1 then ADDI x2=x1+3 with stale src1_value=0: BYPASS_EN -> 9; undefined -> 3.
//  SLL by 4 in progress, flush after 2 cycles -> no out_valid, in_ready=1 next cycle, next ADD correct.
//  out_ready held 0 three cycles -> result/write_addr stable, in_ready=0; release -> new op accepted same cycle.
//  reset_n=0 mid-shift for one posedge -> all outputs 0, out_valid=0, FSM IDLE; rd=0 op never forwarded.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM encodings for the alu_pipe execute stage
// Purpose: op localparams ({funct7[5],funct3}), FSM state type and a shift-op
//          classifier used by alu_pipe and alu_shifter.
// Ports:   none (package).
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - serial barrel-free shifter, SHIFT_STEP bits per cycle
// Purpose: shifts data_i by shamt_i over several cycles. The load cycle already
//          performs the first step, so ceil(shamt/SHIFT_STEP) clock edges are
//          needed in total including the load edge.
// Ports:
//   clk_i      clock
//   reset_n_i  synchronous active-low reset
//   clear_i    abandon any shift in progress
//   load_i     start a new shift with data_i/shamt_i/dir_i/arith_i
//   dir_i      0: left, 1: right
//   arith_i    right shifts replicate the MSB
//   shamt_i    shift amount
//   data_i     value to shift
//   busy_o     steps still outstanding
//   done_o     no steps outstanding, data_o is final
//   last_o     the step taken at the coming edge is the final one
//   data_o     current shifter contents
module alu_shifter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     load_i,
  input  logic                     dir_i,
  input  logic                     arith_i,
  input  logic [$clog2(XLEN)-1:0]  shamt_i,
  input  logic [XLEN-1:0]          data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     last_o,
  output logic [XLEN-1:0]          data_o
);

  localparam int SW = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN is representable.
  localparam logic [SW:0] STEP_W = (SW+1)'(SHIFT_STEP);

  logic [XLEN-1:0] data_q, data_d;
  logic [SW-1:0]   rem_q, rem_d;
  logic            dir_q, arith_q;

  logic [XLEN-1:0] src_data;
  logic [SW-1:0]   src_rem;
  logic            src_dir, src_arith;
  logic [SW:0]     rem_ext;
  logic [SW-1:0]   amt;

  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] d,
                                               input logic [SW-1:0]   n,
                                               input logic            right,
                                               input logic            arith);
    if (!right)
      return d << n;
    else if (arith)
      return $unsigned($signed(d) >>> n);
    else
      return d >> n;
  endfunction

  always_comb begin
    src_data  = load_i ? data_i  : data_q;
    src_rem   = load_i ? shamt_i : rem_q;
    src_dir   = load_i ? dir_i   : dir_q;
    src_arith = load_i ? arith_i : arith_q;
    rem_ext   = {1'b0, src_rem};
    // When rem >= STEP, STEP <= XLEN-1 so the truncation below is lossless.
    amt       = (rem_ext <= STEP_W) ? src_rem : STEP_W[SW-1:0];
    rem_d     = src_rem - amt;
    data_d    = shift_by(src_data, amt, src_dir, src_arith);
    last_o    = (src_rem != '0) && (rem_ext <= STEP_W);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i || (rem_q != '0)) begin
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= src_dir;
      arith_q <= src_arith;
    end
  end

  assign busy_o = (rem_q != '0);
  assign done_o = (rem_q == '0);
  assign data_o = data_q;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - RV32I integer execute stage with valid/ready handshakes
// Purpose: single-cycle logic/arith ops, serial shifts via alu_shifter, one
//          output register feeding the regfile write port. Optional operand
//          forwarding is compiled in with `define ALU_BYPASS_EN.
// Ports:
//   clk, reset_n (sync, active-low), flush (kill in-flight/pending op)
//   in_valid/in_ready   : operation handshake
//   op, use_imm         : {funct7[5],funct3} and operand-B select
//   src1/2_addr, src1/2_value, imm, rd : operands and destination
//   out_valid/out_ready : result handshake
//   write_addr, result  : destination and value of the current result
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            use_imm,
  input  logic [AW-1:0]   src1_addr,
  input  logic [AW-1:0]   src2_addr,
  input  logic [XLEN-1:0] src1_value,
  input  logic [XLEN-1:0] src2_value,
  input  logic [XLEN-1:0] imm,
  input  logic [AW-1:0]   rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   write_addr,
  output logic [XLEN-1:0] result
);

  localparam int SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [AW-1:0]   write_addr_q, write_addr_d;
  logic [AW-1:0]   rd_q;

  logic [XLEN-1:0] opa, opb;
  logic [3:0]      op_eff;
  logic            op_shift;
  logic [SW-1:0]   shamt;
  logic            accept;
  logic [XLEN-1:0] alu_res;

  logic            shf_load, shf_busy, shf_done, shf_last;
  logic [XLEN-1:0] shf_data;

  // ---------------------------------------------------------------- operands
`ifdef ALU_BYPASS_EN
  logic            byp_valid_q;
  logic [AW-1:0]   byp_addr_q;
  logic [XLEN-1:0] byp_data_q;

  // Every result written back to a real register is remembered; a flush does
  // not touch it because the write has already been committed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_data_q  <= '0;
    end else if (out_valid_q && out_ready && (write_addr_q != '0)) begin
      byp_valid_q <= 1'b1;
      byp_addr_q  <= write_addr_q;
      byp_data_q  <= result_q;
    end
  end

  // The output register is younger than the bypass register, so it wins.
  always_comb begin
    opa = src1_value;
    if (out_valid_q && (write_addr_q != '0) && (write_addr_q == src1_addr))
      opa = result_q;
    else if (byp_valid_q && (byp_addr_q == src1_addr))
      opa = byp_data_q;

    opb = src2_value;
    if (use_imm)
      opb = imm;
    else if (out_valid_q && (write_addr_q != '0) && (write_addr_q == src2_addr))
      opb = result_q;
    else if (byp_valid_q && (byp_addr_q == src2_addr))
      opb = byp_data_q;
  end
`else
  logic unused_addr;
  assign unused_addr = ^{src1_addr, src2_addr};

  always_comb begin
    opa = src1_value;
    opb = use_imm ? imm : src2_value;
  end
`endif

  // ------------------------------------------------------------------ decode
  // funct7[5] only selects SUB for register-register ops; ADDI keeps it as ADD.
  assign op_eff   = ((op == OP_SUB) && use_imm) ? OP_ADD : op;
  assign op_shift = is_shift(op_eff);
  assign shamt    = opb[SW-1:0];

  // ---------------------------------------------------------- single cycle ops
  always_comb begin
    alu_res = '0;
    case (op_eff)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
      OP_XOR:  alu_res = opa ^ opb;
      OP_OR:   alu_res = opa | opb;
      OP_AND:  alu_res = opa & opb;
      // Only reaches the output register when shamt == 0.
      OP_SLL, OP_SRL, OP_SRA: alu_res = opa;
      default: alu_res = '0;
    endcase
  end

  // ----------------------------------------------------------------- shifter
  assign shf_load = accept && op_shift && (shamt != '0);

  alu_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .clear_i   (flush),
    .load_i    (shf_load),
    .dir_i     (op_eff != OP_SLL),
    .arith_i   (op_eff == OP_SRA),
    .shamt_i   (shamt),
    .data_i    (opa),
    .busy_o    (shf_busy),
    .done_o    (shf_done),
    .last_o    (shf_last),
    .data_o    (shf_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)
      rd_q <= '0;
    else if (shf_load)
      rd_q <= rd;
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n || flush)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // A shift finishing within the load step goes straight to DONE.
      S_IDLE:  if (shf_load) state_d = shf_last ? S_DONE : S_SHIFT;
      S_SHIFT: if (shf_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The output slot counts as free when its current result leaves this cycle.
  always_comb begin
    in_ready = reset_n && !flush && (state_q == S_IDLE) && !shf_busy &&
               (!out_valid_q || out_ready);
  end

  assign accept = in_valid && in_ready;

  // ------------------------------------------------------- output register
  always_comb begin
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    write_addr_d = write_addr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept && !shf_load) begin
      out_valid_d  = 1'b1;
      result_d     = alu_res;
      write_addr_d = rd;
    end else if ((state_q == S_DONE) && shf_done) begin
      out_valid_d  = 1'b1;
      result_d     = shf_data;
      write_addr_d = rd_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      write_addr_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      write_addr_q <= write_addr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign write_addr = write_addr_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed scoreboard bench for alu_pipe
module tb_alu_pipe;
  import alu_pkg::*;

`ifdef ALU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, use_imm;
  logic [3:0]  op;
  logic [4:0]  src1_addr, src2_addr, rd, write_addr;
  logic [31:0] src1_value, src2_value, imm, result;
  logic        out_valid, out_ready;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [4:0] s1a = 5'd20;
  logic [4:0] s2a = 5'd21;

  alu_pipe dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .use_imm    (use_imm),
    .src1_addr  (src1_addr),
    .src2_addr  (src2_addr),
    .src1_value (src1_value),
    .src2_value (src2_value),
    .imm        (imm),
    .rd         (rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .write_addr (write_addr),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every completed output handshake pops one entry.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {32'd0, result}, {32'd0, e.data});
        check("write_addr", {59'd0, write_addr}, {59'd0, e.addr});
      end
    end
  end

  // Present one op, wait for acceptance (bounded), push its expected result.
  task automatic send(input logic [3:0] o, input logic ui, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] r,
                      input logic [31:0] exp, output int waits);
    bit took;
    op = o; use_imm = ui; rd = r;
    src1_addr = s1a; src2_addr = s2a; src1_value = a;
    if (ui) begin imm = b; src2_value = b ^ 32'h5a5a_5a5a; end
    else    begin src2_value = b; imm = ~b; end
    in_valid = 1'b1;
    waits = 0; took = 1'b0;
    while (!took && waits < 200) begin
      @(negedge clk);
      waits++;
      if (in_ready === 1'b1) begin
        took = 1'b1;
        sb.push_back('{addr: r, data: exp});
      end
    end
    if (!took) check("accept_timeout", {63'd0, took}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid; shifts must hold in_ready low meanwhile.
  task automatic wait_out(input string tag, input int lat);
    int n;
    bit got, seen_ready;
    n = 0; got = 1'b0; seen_ready = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) got = 1'b1;
      else if (in_ready === 1'b1) seen_ready = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    if (lat > 1) check({tag, "_in_ready_busy"}, {63'd0, seen_ready}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  w;
    bit  seen;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    op = OP_ADD; use_imm = 1'b0; rd = 5'd9;
    src1_addr = 5'd20; src2_addr = 5'd21;
    src1_value = 32'd1; src2_value = 32'd2; imm = 32'd0;

    // Reset state, with an op presented that must not be taken.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_write_addr", {59'd0, write_addr}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Single-cycle ops.
    send(OP_ADD, 1'b0, 32'h7fff_ffff, 32'd1, 5'd10, 32'h8000_0000, w);
    wait_out("add_ovf", 1);
    send(OP_SUB, 1'b0, 32'd0, 32'd1, 5'd11, 32'hffff_ffff, w);
    wait_out("sub", 1);
    send(OP_SUB, 1'b1, 32'd5, 32'd3, 5'd12, 32'd8, w);
    wait_out("sub_imm_is_add", 1);
    send(OP_SLT, 1'b0, 32'hffff_ffff, 32'd1, 5'd13, 32'd1, w);
    send(OP_SLTU, 1'b0, 32'hffff_ffff, 32'd1, 5'd14, 32'd0, w);
    send(OP_XOR, 1'b0, 32'hf0f0_1234, 32'h0ff0_5678, 5'd15, 32'hff00_444c, w);
    send(OP_OR, 1'b1, 32'hf0f0_1234, 32'h0ff0_5678, 5'd10, 32'hfff0_567c, w);
    send(OP_AND, 1'b0, 32'hf0f0_1234, 32'h0ff0_5678, 5'd11, 32'h00f0_1230, w);
    send(4'b1010, 1'b0, 32'h1234_5678, 32'h1, 5'd12, 32'd0, w);
    wait_out("undef_op", 1);

    // Serial shifts.
    send(OP_SRA, 1'b1, 32'h8000_0000, 32'd31, 5'd13, 32'hffff_ffff, w);
    wait_out("sra31", 32);
    send(OP_SLL, 1'b1, 32'd1, 32'd0, 5'd14, 32'd1, w);
    wait_out("sll0", 1);
    send(OP_SRL, 1'b0, 32'h8000_0000, 32'd4, 5'd15, 32'h0800_0000, w);
    wait_out("srl4", 5);
    send(OP_SRA, 1'b0, 32'h8000_0000, 32'd4, 5'd10, 32'hf800_0000, w);
    wait_out("sra4", 5);
    send(OP_SLL, 1'b1, 32'd3, 32'd33, 5'd11, 32'd6, w);
    wait_out("sll_wrap", 2);

    // Flush two cycles into a shift; an op offered during the flush is dropped.
    send(OP_SLL, 1'b1, 32'd1, 32'd4, 5'd12, 32'd16, w);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; rd = 5'd15;
    sb.delete();
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (8) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_out", {63'd0, seen}, 64'd0);
    @(posedge clk); #1;
    send(OP_ADD, 1'b0, 32'd40, 32'd2, 5'd13, 32'd42, w);
    wait_out("post_flush_add", 1);

    // Back-pressure: output held, stage stalled, then same-cycle handover.
    out_ready = 1'b0;
    send(OP_ADD, 1'b0, 32'd1, 32'd2, 5'd13, 32'd3, w);
    wait_out("bp", 1);
    repeat (3) begin
      @(negedge clk);
      check("bp_result", {32'd0, result}, 64'd3);
      check("bp_write_addr", {59'd0, write_addr}, 64'd13);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_ADD, 1'b0, 32'd10, 32'd20, 5'd14, 32'd30, w);
    check("bp_accept_same_cycle", 64'(w), 64'd1);
    wait_out("bp_next", 1);

    // Forwarding: output register, rd=0 exclusion, bypass register.
    s1a = 5'd3;
    send(OP_ADD, 1'b1, 32'd5, 32'd1, 5'd1, 32'd6, w);
    s1a = 5'd1;
    send(OP_ADD, 1'b1, 32'd0, 32'd3, 5'd2, BYP ? 32'd9 : 32'd3, w);
    s1a = 5'd20;
    send(OP_ADD, 1'b1, 32'd100, 32'd0, 5'd0, 32'd100, w);
    s1a = 5'd0;
    send(OP_ADD, 1'b1, 32'd7, 32'd1, 5'd0, 32'd8, w);
    wait_out("rd0_no_fwd", 1);
    repeat (2) begin @(posedge clk); #1; end
    s1a = 5'd2;
    send(OP_ADD, 1'b1, 32'd0, 32'd0, 5'd4, BYP ? 32'd9 : 32'd0, w);
    wait_out("byp_reg_a", 1);
    s1a = 5'd20; s2a = 5'd4;
    send(OP_ADD, 1'b0, 32'd1, 32'd0, 5'd5, BYP ? 32'd10 : 32'd1, w);
    wait_out("byp_reg_b", 1);
    send(OP_ADD, 1'b1, 32'd1, 32'd2, 5'd6, 32'd3, w);
    wait_out("imm_not_bypassed", 1);
    s2a = 5'd21;

    // Reset in the middle of a shift.
    send(OP_ADD, 1'b0, 32'd1, 32'd2, 5'd7, 32'd3, w);
    wait_out("pre_rst_add", 1);
    send(OP_SLL, 1'b1, 32'd5, 32'd10, 5'd14, 32'd5120, w);
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0; in_valid = 1'b1; op = OP_ADD; rd = 5'd9;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_write_addr", {59'd0, write_addr}, 64'd0);
    check("midrst_idle_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (12) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_out", {63'd0, seen}, 64'd0);
    @(posedge clk); #1;
    s1a = 5'd2;
    send(OP_ADD, 1'b1, 32'h11, 32'd0, 5'd3, 32'h11, w);
    wait_out("post_rst_no_byp", 1);
    s1a = 5'd20;

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
